updown_load_counter: RTL and testbench



---
 rtl/updown_load_counter_if.sv | 57 +++++
 rtl/updown_load_counter.sv | 63 ++++++
 tb/tb_updown_load_counter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/updown_load_counter_if.sv
// ---------------------------------------------------------------------------
// updown_load_counter_if
//
// Purpose: groups the control and data signals of updown_load_counter into a
// single bundle. clk and res stay plain ports on the counter itself.
//
// Parameters:
//   N         counter width in bits (N >= 1)
//
// Signals:
//   en        count enable (1 = step once per clock, 0 = hold)
//   count_up  direction (1 = increment, 0 = decrement)
//   load      synchronous parallel load strobe
//   set       value loaded when load = 1
//   count     registered counter value
//   tc        terminal-count flag, present only when COUNTER_TC_EN is defined
//
// Modports:
//   master    the side that drives the controls and observes count
//   slave     the counter side
// ---------------------------------------------------------------------------
interface updown_load_counter_if #(
  parameter int N = 4
);

  logic         en;
  logic         count_up;
  logic         load;
  logic [N-1:0] set;
  logic [N-1:0] count;
`ifdef COUNTER_TC_EN
  logic         tc;
`endif

`ifdef COUNTER_TC_EN
  modport master (
    output en, count_up, load, set,
    input  count, tc
  );

  modport slave (
    input  en, count_up, load, set,
    output count, tc
  );
`else
  modport master (
    output en, count_up, load, set,
    input  count
  );

  modport slave (
    input  en, count_up, load, set,
    output count
  );
`endif

endinterface

// File: rtl/updown_load_counter.sv
// ---------------------------------------------------------------------------
// updown_load_counter
//
// Purpose: synchronous N-bit binary up/down counter with count enable and
// parallel load. The count wraps modulo 2^N in both directions.
//
// Optional feature macro: COUNTER_TC_EN
//   When defined, the bus carries a combinational terminal-count flag tc that
//   is high exactly in the cycle whose next rising edge wraps the counter.
//
// Parameters:
//   N      counter width in bits (N >= 1); must match the bus instance
//
// Ports:
//   clk    clock; all state changes on the rising edge
//   res    synchronous active-high reset; clears the counter
//   bus    updown_load_counter_if.slave (en, count_up, load, set, count[, tc])
//
// Per-edge priority, highest first: res, load, enabled up/down step, hold.
// ---------------------------------------------------------------------------
module updown_load_counter #(
  parameter int N = 4
) (
  input  logic                    clk,
  input  logic                    res,
  updown_load_counter_if.slave    bus
);

  // Step of one, sized to the counter so the add/subtract wraps naturally.
  localparam logic [N-1:0] STEP  = N'(1);
  localparam logic [N-1:0] MAX_V = {N{1'b1}};

  logic [N-1:0] count_q;

  // Counter register. Reset beats load, load beats counting, and load ignores
  // en and count_up entirely. The N-bit add/subtract gives the modulo 2^N
  // wrap (max -> 0 going up, 0 -> max going down) without extra logic.
  always_ff @(posedge clk) begin
    if (res) begin
      count_q <= '0;
    end else if (bus.load) begin
      count_q <= bus.set;
    end else if (bus.en) begin
      if (bus.count_up) begin
        count_q <= count_q + STEP;
      end else begin
        count_q <= count_q - STEP;
      end
    end
  end

  assign bus.count = count_q;

`ifdef COUNTER_TC_EN
  // Terminal count looks at the registered value together with the live
  // controls, so it flags the wrap one cycle ahead of it happening and is
  // suppressed whenever reset or load will take the edge instead.
  assign bus.tc = bus.en & ~bus.load & ~res &
                  (( bus.count_up & (count_q == MAX_V)) |
                   (~bus.count_up & (count_q == '0)));
`endif

endmodule

// File: tb/tb_updown_load_counter.sv
// ---------------------------------------------------------------------------
// tb_updown_load_counter
//
// Self-checking bench for updown_load_counter with N = 4: a table of
// directed vectors, hand-written multi-cycle sequences (wrap up, wrap down,
// hold, load then count, priority) and a randomized run compared against an
// arithmetic reference model. With COUNTER_TC_EN defined, tc is also checked
// before every edge.
// ---------------------------------------------------------------------------
module tb_updown_load_counter;

  localparam int N    = 4;
  localparam int MODV = 16;

  typedef struct {
    string      name;
    logic       res;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] set;
    logic [3:0] exp_count;
  } vec_t;

  logic clk;
  logic res;

  int   pass_count;
  int   total_count;
  int   model_count;

  vec_t vecs [10];

  updown_load_counter_if #(.N(N)) bus_if ();

  updown_load_counter #(.N(N)) dut (
    .clk (clk),
    .res (res),
    .bus (bus_if.slave)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one counter value against its expectation.
  task automatic checkOutput(input string name, input logic [3:0] actual,
                             input logic [3:0] expected);
    total_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: count=%0d expected %0d", name, actual, expected);
    end
  endtask

`ifdef COUNTER_TC_EN
  // Compare the terminal-count flag against the rule: it flags a wrap on
  // the coming edge, and never while reset or load take that edge.
  task automatic checkTc(input string name);
    logic tc_exp;
    tc_exp = bus_if.en && !bus_if.load && !res &&
             ((bus_if.count_up && model_count == MODV - 1) ||
              (!bus_if.count_up && model_count == 0));
    total_count++;
    if (bus_if.tc === tc_exp) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s tc: tc=%b expected %b (count=%0d)",
               name, bus_if.tc, tc_exp, model_count);
    end
  endtask
`endif

  // Drive one cycle of inputs, let the edge happen, and advance the model.
  task automatic applyStimulus(input string name, input logic r, input logic e,
                               input logic u, input logic l,
                               input logic [3:0] s);
    res             = r;
    bus_if.en       = e;
    bus_if.count_up = u;
    bus_if.load     = l;
    bus_if.set      = s;
    #1;
`ifdef COUNTER_TC_EN
    if (total_count > 0) checkTc(name);
`endif
    @(posedge clk);
    #1;
    if (r)           model_count = 0;
    else if (l)      model_count = int'(s);
    else if (e && u) model_count = (model_count + 1) % MODV;
    else if (e)      model_count = (model_count + MODV - 1) % MODV;
  endtask

  initial begin
    pass_count      = 0;
    total_count     = 0;
    model_count     = 0;
    res             = 1'b1;
    bus_if.en       = 1'b0;
    bus_if.count_up = 1'b1;
    bus_if.load     = 1'b0;
    bus_if.set      = '0;

    // Directed vectors: name, res, en, up, load, set, expected count.
    vecs[0] = '{"reset",          1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  4'd0};
    vecs[1] = '{"reset_hold_en",  1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  4'd0};
    vecs[2] = '{"first_up",       1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  4'd1};
    vecs[3] = '{"down_to_zero",   1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd0};
    vecs[4] = '{"wrap_down",      1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd15};
    vecs[5] = '{"wrap_up",        1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  4'd0};
    vecs[6] = '{"load_no_en",     1'b0, 1'b0, 1'b0, 1'b1, 4'd7,  4'd7};
    vecs[7] = '{"res_over_load",  1'b1, 1'b1, 1'b1, 1'b1, 4'd9,  4'd0};
    vecs[8] = '{"load_over_en",   1'b0, 1'b1, 1'b0, 1'b1, 4'd12, 4'd12};
    vecs[9] = '{"hold",           1'b0, 1'b0, 1'b0, 1'b0, 4'd3,  4'd12};

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].name, vecs[i].res, vecs[i].en, vecs[i].up,
                    vecs[i].load, vecs[i].set);
      checkOutput(vecs[i].name, bus_if.count, vecs[i].exp_count);
    end

    // Reset, then 30 steps up through the 15 -> 0 wrap.
    applyStimulus("seq_reset", 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    checkOutput("seq_reset", bus_if.count, 4'd0);
    for (int i = 1; i <= 30; i++) begin
      applyStimulus("count_up", 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      checkOutput("count_up", bus_if.count, 4'(i % MODV));
    end

    // Hold at 14, then 32 steps down through the 0 -> 15 wrap twice.
    applyStimulus("hold14", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    checkOutput("hold14", bus_if.count, 4'd14);
    for (int i = 1; i <= 32; i++) begin
      applyStimulus("count_down", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      checkOutput("count_down", bus_if.count, 4'(((14 - i) % MODV + MODV) % MODV));
    end

    // Disabled: direction and set toggle freely, value must not move.
    for (int i = 0; i < 16; i++) begin
      applyStimulus("disabled", 1'b0, 1'b0, 1'(i % 2), 1'b0, 4'($urandom));
      checkOutput("disabled", bus_if.count, 4'd14);
    end

    // Load 15 while enabled, then count down through 0 -> 15.
    applyStimulus("load15", 1'b0, 1'b1, 1'b1, 1'b1, 4'd15);
    checkOutput("load15", bus_if.count, 4'd15);
    for (int i = 1; i <= 16; i++) begin
      applyStimulus("down_after_load", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      checkOutput("down_after_load", bus_if.count, 4'((15 - i + MODV) % MODV));
    end

    // Priority: reset beats load, load works without enable.
    applyStimulus("prio_res_load", 1'b1, 1'b0, 1'b1, 1'b1, 4'd9);
    checkOutput("prio_res_load", bus_if.count, 4'd0);
    applyStimulus("prio_load_noen", 1'b0, 1'b0, 1'b1, 1'b1, 4'd7);
    checkOutput("prio_load_noen", bus_if.count, 4'd7);

    // Randomized run against the reference model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus("random",
                    1'($urandom_range(0, 19) == 0),
                    1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 5) == 0),
                    4'($urandom));
      checkOutput("random", bus_if.count, 4'(model_count));
    end

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
